ex_mdu: RTL

Execute-stage multiply/divide unit for the 5-stage MIPS32 pipeline. It sits beside the logic/shift ALU in EX and consumes the `aluop`/`reg1`/`reg2` triple the decode stage produces, latched through the ID/EX register. MULT/MULTU complete in one cycle. DIV/DIVU run a 32-iteration restoring divider that stalls the pipeline until the HI/LO result is ready.

---
 rtl/ex_mdu_pkg.sv | 27 ++
 rtl/ex_mdu_div_step.sv | 22 ++
 rtl/ex_mdu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// MDU opcodes, FSM state encodings, divider iteration default and helpers.
package ex_mdu_pkg;

   localparam logic [7:0] OP_MULT  = 8'b00011000;
   localparam logic [7:0] OP_MULTU = 8'b00011001;
   localparam logic [7:0] OP_DIV   = 8'b00011010;
   localparam logic [7:0] OP_DIVU  = 8'b00011011;

   localparam int unsigned DIV_ITERS_DEF = 32;
   localparam int unsigned WORD_W        = 32;

   localparam logic [31:0] ZEROWORD = 32'h0000_0000;
   localparam logic [31:0] ONESWORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   // Two's-complement negate when en is set; used for magnitudes and sign fix-up.
   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
      return en ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference and emit a quotient 1 when it does not go negative.
module div_step (
   input  logic [32:0] rem_i,
   input  logic        bit_i,
   input  logic [31:0] divisor_i,
   output logic [32:0] rem_o,
   output logic        q_o
);

   logic [33:0] shifted;
   logic [32:0] diff;

   // Trial subtraction and restore select
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = 33'(shifted) - {1'b0, divisor_i};
      q_o     = (shifted >= {2'b00, divisor_i});
      rem_o   = q_o ? diff : 33'(shifted);
   end

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit. MULT/MULTU finish in the issue cycle;
// DIV/DIVU run a restoring divider and stall the pipeline until HI/LO are ready.
// Optional feature macro: MDU_DIVZERO_FAST_EN (zero divisor skips the iterations
// and raises div_zero_o for the result cycle).
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int unsigned DIV_ITERS = DIV_ITERS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        annul_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   output logic        stallreq_o,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
`ifdef MDU_DIVZERO_FAST_EN
   ,
   output logic        div_zero_o
`endif
);

   localparam int unsigned CNT_W = $clog2(DIV_ITERS + 1);

   mdu_state_e  state;
   logic [CNT_W-1:0] cnt;
   logic [32:0] rem_q;
   logic [31:0] dvd_q;
   logic [31:0] dsr_q;
   logic        qneg_q;
   logic        rneg_q;
   logic        dz_q;

   logic        is_mul;
   logic        is_div;
   logic        op_signed;
   logic [31:0] abs1;
   logic [31:0] abs2;
   logic        div_zero_in;
   logic [63:0] ext1;
   logic [63:0] ext2;
   logic [63:0] prod;
   logic [32:0] step_rem;
   logic        step_q;

   // Opcode decode, operand magnitudes and the single-cycle product
   always_comb begin
      is_mul      = valid_i && ((aluop_i == OP_MULT) || (aluop_i == OP_MULTU));
      is_div      = valid_i && ((aluop_i == OP_DIV)  || (aluop_i == OP_DIVU));
      op_signed   = ~aluop_i[0];
      abs1        = neg_if(reg1_i, op_signed && reg1_i[31]);
      abs2        = neg_if(reg2_i, op_signed && reg2_i[31]);
      div_zero_in = (reg2_i == ZEROWORD);
      ext1        = op_signed ? {{32{reg1_i[31]}}, reg1_i} : {ZEROWORD, reg1_i};
      ext2        = op_signed ? {{32{reg2_i[31]}}, reg2_i} : {ZEROWORD, reg2_i};
      prod        = ext1 * ext2;
   end

   div_step u_div_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[31]),
      .divisor_i (dsr_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   // Divider FSM: operand latch on issue, one quotient bit per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         rem_q  <= '0;
         dvd_q  <= ZEROWORD;
         dsr_q  <= ZEROWORD;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
      end else if (annul_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (is_div) begin
                  dvd_q  <= abs1;
                  dsr_q  <= abs2;
                  qneg_q <= op_signed && (reg1_i[31] ^ reg2_i[31]);
                  rneg_q <= op_signed && reg1_i[31];
                  dz_q   <= div_zero_in;
                  cnt    <= '0;
`ifdef MDU_DIVZERO_FAST_EN
                  // Zero divisor: remainder is the dividend, no iterations needed
                  if (div_zero_in) begin
                     rem_q <= {1'b0, abs1};
                     state <= ST_DONE;
                  end else begin
                     rem_q <= '0;
                     state <= ST_RUN;
                  end
`else
                  rem_q <= '0;
                  state <= ST_RUN;
`endif
               end
            end
            ST_RUN: begin
               rem_q <= step_rem;
               dvd_q <= {dvd_q[30:0], step_q};
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Stall, HI/LO write and result muxing; flush suppresses everything
   always_comb begin
      stallreq_o = 1'b0;
      hilo_we_o  = 1'b0;
      hi_o       = ZEROWORD;
      lo_o       = ZEROWORD;
`ifdef MDU_DIVZERO_FAST_EN
      div_zero_o = 1'b0;
`endif
      if (!annul_i) begin
         case (state)
            ST_IDLE: begin
               if (is_mul) begin
                  hilo_we_o = 1'b1;
                  hi_o      = prod[63:32];
                  lo_o      = prod[31:0];
               end else if (is_div) begin
                  stallreq_o = 1'b1;
               end
            end
            ST_RUN: begin
               stallreq_o = 1'b1;
            end
            ST_DONE: begin
               hilo_we_o = 1'b1;
               // Zero divisor: sign-corrected remainder equals the raw dividend
               hi_o      = neg_if(rem_q[31:0], rneg_q);
               lo_o      = dz_q ? ONESWORD : neg_if(dvd_q, qneg_q);
`ifdef MDU_DIVZERO_FAST_EN
               div_zero_o = dz_q;
`endif
            end
            default: begin
               stallreq_o = 1'b0;
            end
         endcase
      end
   end

endmodule
